// File: rtl/neuron_mac_sequencer.sv
// Single-neuron MAC sequencer: streams N_IN activations against weights read from a
// falling-edge BRAM, then adds bias, rescales, saturates, optionally ReLUs and emits one result.
`timescale 1ns/1ps

module neuron_mac_sequencer #(
  parameter int N_IN   = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int RELU   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              W_WE,
  output logic [DATA_W-1:0] W_DI,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DATA,
  input  logic              X_VALID,
  output logic              X_READY,
  output logic [DATA_W-1:0] Y_DATA,
  output logic              Y_VALID,
  input  logic              Y_READY,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_IN - 1);
  localparam logic [ACC_W-1:0]  ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [DATA_W-1:0] Y_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                    state_r, state_s;
  logic [ADDR_W-1:0]         idx_r, idx_s;
  logic [ADDR_W-1:0]         addr_r, addr_s;
  logic signed [ACC_W-1:0]   acc_r, acc_s;
  logic [DATA_W-1:0]         bias_r, bias_s;
  logic                      en_r, en_s;
  logic                      xrdy_r, xrdy_s;
  logic [DATA_W-1:0]         y_r, y_s;
  logic                      yv_r, yv_s;
  logic                      busy_r;

  logic signed [2*DATA_W-1:0] w_ext_s, x_ext_s, prod_s;
  logic signed [ACC_W-1:0]    prod_acc_s, bias_ext_s, sum_s, scaled_s;
  logic [DATA_W-1:0]          result_s;

  // Clamp a rescaled accumulator value into the signed output range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] upper;
    upper = v[ACC_W-1:DATA_W-1];
    if (v[ACC_W-1] && !(&upper)) begin
      saturate = Y_MIN;
    end else if (!v[ACC_W-1] && (|upper)) begin
      saturate = Y_MAX;
    end else begin
      saturate = v[DATA_W-1:0];
    end
  endfunction

  // Optional rectification of the saturated result.
  function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] v);
    if ((RELU != 0) && v[DATA_W-1]) begin
      rectify = {DATA_W{1'b0}};
    end else begin
      rectify = v;
    end
  endfunction

  // Full-precision product and output rescale datapath.
  always_comb begin
    w_ext_s    = {{DATA_W{W_DO[DATA_W-1]}}, W_DO};
    x_ext_s    = {{DATA_W{X_DATA[DATA_W-1]}}, X_DATA};
    prod_s     = w_ext_s * x_ext_s;
    prod_acc_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    bias_ext_s = {{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r};
    // Bias is Q8.8; align it to the Q16.16 accumulator before summing.
    sum_s      = acc_r + (bias_ext_s <<< FRAC);
    scaled_s   = sum_s >>> FRAC;
    result_s   = rectify(saturate(scaled_s));
  end

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    addr_s  = addr_r;
    acc_s   = acc_r;
    bias_s  = bias_r;
    en_s    = en_r;
    xrdy_s  = xrdy_r;
    y_s     = y_r;
    yv_s    = yv_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_s = S_PRIME;
          bias_s  = BIAS;
          idx_s   = IDX_ZERO;
          addr_s  = IDX_ZERO;
          en_s    = 1'b1;
          acc_s   = ACC_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PRIME: begin
        // The BRAM sees address 0 on this cycle's falling edge, so W[0] is ready for RUN.
        state_s = S_RUN;
        xrdy_s  = 1'b1;
      end
      S_RUN: begin
        if (X_VALID && xrdy_r) begin
          acc_s = acc_r + prod_acc_s;
          if (idx_r == IDX_LAST) begin
            state_s = S_CALC;
            en_s    = 1'b0;
            xrdy_s  = 1'b0;
            idx_s   = IDX_ZERO;
            addr_s  = IDX_ZERO;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            addr_s  = idx_r + IDX_ONE;
          end
        end else begin
          state_s = S_RUN;
        end
      end
      S_CALC: begin
        state_s = S_OUT;
        y_s     = result_s;
        yv_s    = 1'b1;
      end
      S_OUT: begin
        if (Y_READY) begin
          state_s = S_IDLE;
          yv_s    = 1'b0;
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s = S_IDLE;
        idx_s   = IDX_ZERO;
        addr_s  = IDX_ZERO;
        acc_s   = ACC_ZERO;
        en_s    = 1'b0;
        xrdy_s  = 1'b0;
        yv_s    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= S_IDLE;
      idx_r   <= IDX_ZERO;
      addr_r  <= IDX_ZERO;
      acc_r   <= ACC_ZERO;
      bias_r  <= {DATA_W{1'b0}};
      en_r    <= 1'b0;
      xrdy_r  <= 1'b0;
      y_r     <= {DATA_W{1'b0}};
      yv_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      addr_r  <= addr_s;
      acc_r   <= acc_s;
      bias_r  <= bias_s;
      en_r    <= en_s;
      xrdy_r  <= xrdy_s;
      y_r     <= y_s;
      yv_r    <= yv_s;
      busy_r  <= (state_s != S_IDLE);
    end
  end

  assign W_ADDR  = addr_r;
  assign W_EN    = en_r;
  assign W_WE    = 1'b0;
  assign W_DI    = {DATA_W{1'b0}};
  assign X_READY = xrdy_r;
  assign Y_DATA  = y_r;
  assign Y_VALID = yv_r;
  assign BUSY    = busy_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench: two DUTs (RELU=1 and RELU=0) share stimulus and a falling-edge
// BRAM model; results are compared with a plain-arithmetic dot-product reference.
`timescale 1ns/1ps

module tb_neuron_mac_sequencer;
  localparam int N_IN = 28;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] BIAS = 16'h0000;
  logic [15:0] X_DATA = 16'h0000;
  logic        X_VALID = 1'b0;
  logic        Y_READY = 1'b0;

  logic [4:0]  r_w_addr, l_w_addr;
  logic        r_w_en, l_w_en, r_w_we, l_w_we;
  logic [15:0] r_w_di, l_w_di;
  logic [15:0] r_w_do = 16'h0000, l_w_do = 16'h0000;
  logic        r_x_ready, l_x_ready, r_y_valid, l_y_valid, r_busy, l_busy;
  logic [15:0] r_y_data, l_y_data;

  logic signed [15:0] w_mem [N_IN];
  logic signed [15:0] x_vec [N_IN];
  logic signed [15:0] bias_v;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  neuron_mac_sequencer #(.RELU(1)) u_relu (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIAS(BIAS),
    .W_ADDR(r_w_addr), .W_EN(r_w_en), .W_WE(r_w_we), .W_DI(r_w_di), .W_DO(r_w_do),
    .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(r_x_ready),
    .Y_DATA(r_y_data), .Y_VALID(r_y_valid), .Y_READY(Y_READY), .BUSY(r_busy)
  );

  neuron_mac_sequencer #(.RELU(0)) u_lin (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIAS(BIAS),
    .W_ADDR(l_w_addr), .W_EN(l_w_en), .W_WE(l_w_we), .W_DI(l_w_di), .W_DO(l_w_do),
    .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(l_x_ready),
    .Y_DATA(l_y_data), .Y_VALID(l_y_valid), .Y_READY(Y_READY), .BUSY(l_busy)
  );

  // Weight BRAM: read port sampled on the falling edge.
  always @(negedge CLK) begin
    if (r_w_en) r_w_do <= w_mem[r_w_addr];
    if (l_w_en) l_w_do <= w_mem[l_w_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: exact integer dot product, Q8.8 rescale by floor division, clamp, ReLU.
  function automatic logic [15:0] model(input bit relu);
    longint sum;
    longint s;
    sum = 0;
    for (int k = 0; k < N_IN; k++) sum += longint'(w_mem[k]) * longint'(x_vec[k]);
    sum += longint'(bias_v) * 256;
    s = sum >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, {r_w_addr, l_w_addr}, 32'h0);
    check({tag, "_en"}, {r_w_en, l_w_en}, 32'h0);
    check({tag, "_xrdy"}, {r_x_ready, l_x_ready}, 32'h0);
    check({tag, "_yv"}, {r_y_valid, l_y_valid}, 32'h0);
    check({tag, "_yd"}, {r_y_data, l_y_data}, 32'h0);
    check({tag, "_busy"}, {r_busy, l_busy}, 32'h0);
  endtask

  task automatic run_neuron(input int stall_pct, input int yhold, input bit poke_start,
                            output logic [15:0] yr, output logic [15:0] yl);
    int k, cyc, guard;
    bit acc_now, in_run;
    logic [4:0] addr_b;
    BIAS = bias_v;
    START = 1'b1;
    tick();
    START = 1'b0;
    cyc = 1; k = 0; guard = 0;
    while (k < N_IN && guard < 400) begin
      X_VALID = ($urandom_range(0, 99) >= stall_pct);
      X_DATA  = X_VALID ? x_vec[k] : 16'($urandom);
      START   = poke_start && (k == 5);
      acc_now = X_VALID && r_x_ready;
      in_run  = r_x_ready;
      addr_b  = r_w_addr;
      tick();
      START = 1'b0;
      cyc++; guard++;
      if (acc_now) begin
        check("addr_at_accept", addr_b, k);
        k++;
      end else if (in_run) begin
        check("addr_stall", r_w_addr, addr_b);
      end
    end
    X_VALID = 1'b0;
    check("accept_count", k, N_IN);
    guard = 0;
    while (!r_y_valid && guard < 20) begin
      tick();
      cyc++; guard++;
    end
    check("y_valid_rise", {r_y_valid, l_y_valid}, 32'h3);
    if (stall_pct == 0) check("latency", cyc, N_IN + 3);
    check("y_relu", r_y_data, model(1'b1));
    check("y_lin", l_y_data, model(1'b0));
    yr = r_y_data;
    yl = l_y_data;
    for (int i = 0; i < yhold; i++) begin
      START = poke_start && (i == 3);
      tick();
      START = 1'b0;
      check("y_hold_valid", r_y_valid, 1);
      check("y_hold_data", {r_y_data, l_y_data}, {yr, yl});
    end
    Y_READY = 1'b1;
    START = poke_start;
    tick();
    Y_READY = 1'b0;
    START = 1'b0;
    check("y_drop", {r_y_valid, l_y_valid}, 32'h0);
    check("idle_after", {r_busy, l_busy}, 32'h0);
    tick();
    tick();
    check("no_second_output", {r_y_valid, l_y_valid, r_busy}, 32'h0);
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    int k, guard;
    bit acc_now;
    bit seen;

    repeat (2) tick();
    check_reset_outputs("rst");
    check("rst_we_di", {r_w_we, r_w_di, l_w_we, l_w_di}, 32'h0);
    RST_N = 1'b1;
    tick();

    // All ones
    for (int i = 0; i < N_IN; i++) begin w_mem[i] = 16'h0100; x_vec[i] = 16'h0100; end
    bias_v = 16'h0000;
    run_neuron(0, 0, 1'b0, a, b);
    check("ones_r", a, 16'h1C00);
    check("ones_l", b, 16'h1C00);

    // Mixed with negative bias
    for (int i = 0; i < N_IN; i++) begin w_mem[i] = 16'h0080; x_vec[i] = 16'(i << 8); end
    bias_v = 16'hFF00;
    run_neuron(0, 0, 1'b0, a, b);
    check("mixed_sat_r", a, 16'h7FFF);
    check("mixed_sat_l", b, 16'h7FFF);
    for (int i = 0; i < N_IN; i++) x_vec[i] = 16'h0100;
    run_neuron(0, 0, 1'b0, a, b);
    check("mixed_13_r", a, 16'h0D00);
    check("mixed_13_l", b, 16'h0D00);

    // Saturation and ReLU
    for (int i = 0; i < N_IN; i++) begin w_mem[i] = 16'h7FFF; x_vec[i] = 16'h7FFF; end
    bias_v = 16'h0000;
    run_neuron(0, 0, 1'b0, a, b);
    check("satpos_r", a, 16'h7FFF);
    check("satpos_l", b, 16'h7FFF);
    for (int i = 0; i < N_IN; i++) w_mem[i] = 16'h8000;
    run_neuron(0, 0, 1'b0, a, b);
    check("satneg_relu", a, 16'h0000);
    check("satneg_lin", b, 16'h8000);

    // Random vectors: clean run vs. stalled run with ignored STARTs
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        x_vec[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      bias_v = 16'($urandom_range(0, 2047)) - 16'd1024;
      run_neuron(0, 0, 1'b0, a, b);
      run_neuron(50, 10, 1'b1, c, d);
      check("stall_eq_r", c, a);
      check("stall_eq_l", d, b);
    end

    // Reset after 10 accepts
    BIAS = bias_v;
    START = 1'b1;
    tick();
    START = 1'b0;
    X_VALID = 1'b1;
    k = 0; guard = 0;
    while (k < 10 && guard < 50) begin
      X_DATA = x_vec[k];
      acc_now = r_x_ready;
      tick();
      if (acc_now) k++;
      guard++;
    end
    check("midop_accepts", k, 10);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    X_VALID = 1'b0;
    check_reset_outputs("midrst");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (r_y_valid || l_y_valid || r_busy) seen = 1'b1;
    end
    check("midrst_quiet", seen, 0);
    run_neuron(0, 0, 1'b0, a, b);
    check("after_rst_r", a, model(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Consumer stage for one per-neuron weight BRAM: 28 x 16-bit words, read port sampled on the falling edge of CLK, one-cycle read latency as seen from a rising-edge consumer.
- Drives the BRAM address/enable and accepts a stream of N_IN activations over a valid/ready handshake.
- Computes the signed multiply-accumulate dot product, adds a bias, rescales, saturates and optionally applies ReLU.
- Returns one 16-bit neuron output over a valid/ready handshake to the next layer.

Parameters:
- N_IN, 28, number of inputs and weights per neuron.
- ADDR_W, 5, BRAM address width.
- DATA_W, 16, weight/activation/output width; signed two's complement, Q8.8.
- FRAC, 8, fractional bits; each product is Q16.16.
- ACC_W, 40, accumulator width; 37 bits are needed, the rest is margin.
- RELU, 1, 1 = clamp negative results to 0, 0 = pass signed result.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  one-cycle pulse; begins a neuron evaluation when idle.
- BIAS  in  DATA_W  signed Q8.8 bias, sampled on accepted START.
- W_ADDR  out  ADDR_W  BRAM address.
- W_EN  out  1  BRAM enable.
- W_WE  out  1  BRAM write enable, constant 0.
- W_DI  out  DATA_W  BRAM write data, constant 0.
- W_DO  in  DATA_W  BRAM read data.
- X_DATA  in  DATA_W  signed Q8.8 activation.
- X_VALID  in  1  activation valid.
- X_READY  out  1  activation accepted when X_VALID & X_READY at a rising edge.
- Y_DATA  out  DATA_W  neuron output.
- Y_VALID  out  1  output valid.
- Y_READY  in  1  downstream accepts on Y_VALID & Y_READY.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N=0 at rising edge):
  - state=IDLE; W_ADDR=0; W_EN=0; X_READY=0; Y_VALID=0; Y_DATA=0; BUSY=0.
  - Accumulator, index and bias register cleared.
  - Applies from any state, including mid-stream; a partial sum is discarded, never output.
- IDLE: on START=1, latch BIAS, set idx=0, W_ADDR=0, W_EN=1, acc=0, go to PRIME. START is ignored in every other state.
- PRIME (exactly 1 cycle):
  - X_READY=0, so the BRAM falling edge loads W[0] before the first accept.
  - Go to RUN.
- RUN:
  - X_READY=1.
  - On accept: acc <= acc + sext(W_DO*X_DATA), full 32-bit signed product.
  - On the same edge, W_ADDR <= idx+1 and idx <= idx+1.
  - Guarantees W_DO = W[idx] at every accept edge; throughput is 1 activation/cycle with no bubbles.
  - X_VALID=0 holds all state, and W_ADDR stays stable.
  - On accept of idx = N_IN-1: W_EN <= 0, X_READY <= 0, go to CALC. W_ADDR does not advance past N_IN-1; it returns to 0.
- CALC (1 cycle):
  - s = (acc + (sext(bias) <<< FRAC)) >>> FRAC, arithmetic shift, truncation toward -inf.
  - Saturate s to [-32768, 32767].
  - If RELU=1 and s<0, s=0.
  - Y_DATA <= s; Y_VALID <= 1; go to OUT.
- OUT:
  - Y_DATA and Y_VALID are held stable until Y_READY=1.
  - On handshake: Y_VALID <= 0, go to IDLE.
  - A START arriving in the same cycle as the handshake is ignored; the next START is accepted from IDLE.
- Latency: START to Y_VALID = N_IN + 3 cycles with X_VALID continuously high (1 IDLE->PRIME, 1 PRIME, N_IN RUN, 1 CALC).
- Accumulator: does not overflow for N_IN <= 256 with ACC_W=40; no intermediate saturation.
- W_WE and W_DI: tied 0. The block never writes the BRAM.

Test Plan:
- Ones: all W = 0x0100, all X = 0x0100, BIAS=0, X_VALID constant -> Y_DATA=0x1C00 (28.0); Y_VALID asserted 31 cycles after START; W_ADDR sequence 0..27 with no repeats or skips.
- Mixed/bias: W[k]=0x0080 (0.5), X[k]=k<<8, BIAS=0xFF00 (-1.0) -> sum 189.0 => s=188.0, saturates to 0x7FFF; repeat with X[k]=0x0100 -> 0x0D00 (13.0).
- Saturation/ReLU: all W=0x7FFF, X=0x7FFF -> 0x7FFF; all W=0x8000, X=0x7FFF -> RELU=1 gives 0x0000, RELU=0 gives 0x8000.
- Stalls: X_VALID randomly deasserted (≈50%); Y_READY held low 10 cycles -> result identical to the no-stall run; Y_DATA stable while Y_VALID & !Y_READY; W_ADDR unchanged during X stalls.
- Reset mid-op: RST_N=0 for 1 cycle after 10 accepts -> all outputs at reset values next cycle, no Y_VALID; a fresh START then produces the correct full result.
- Ignored START: pulse START during RUN and OUT -> no restart; idx and accumulator unaffected; exactly one output per accepted START.
